// File: rtl/goertzel_pkg.sv
// goertzel_pkg: shared state encodings and default sizing for the Goertzel sequencer
package goertzel_pkg;
    localparam int DEF_NUM_BINS    = 4;
    localparam int DEF_BLOCK_LEN   = 520;
    localparam int DEF_TIMEOUT_CYC = 64;
    typedef logic [1:0] rec_state_t;
    typedef logic [1:0] pwr_state_t;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_BOUND = 2'd3;
    localparam logic [1:0] P_IDLE  = 2'd0;
    localparam logic [1:0] P_ISSUE = 2'd1;
    localparam logic [1:0] P_WAIT  = 2'd2;
    localparam logic [1:0] P_FIN   = 2'd3;
endpackage

// File: rtl/goertzel_pwr_seq.sv
// goertzel_pwr_seq: walks the power unit over all bins after a snapshot; watchdog with GOERTZEL_SCHED_TIMEOUT_EN
module goertzel_pwr_seq
    import goertzel_pkg::*;
#(
    parameter int NUM_BINS = DEF_NUM_BINS,
`ifdef GOERTZEL_SCHED_TIMEOUT_EN
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
`endif
    parameter int BIN_W = 2
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_snap,
    input  logic             i_pwr_done,
    output logic             o_pwr_start,
    output logic [BIN_W-1:0] o_pwr_bin,
    output logic             o_frame_done,
    output logic             o_busy,
`ifdef GOERTZEL_SCHED_TIMEOUT_EN
    output logic             o_pwr_timeout,
`endif
    output logic             o_proto_err
);
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);
    pwr_state_t r_state;
    logic       w_adv;
    assign o_busy      = r_state != P_IDLE;
    assign o_proto_err = i_pwr_done && r_state != P_WAIT;
`ifdef GOERTZEL_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] r_wd;
    logic            w_expire;
    assign w_expire = r_state == P_WAIT && !i_pwr_done && r_wd == WD_W'(TIMEOUT_CYC - 1);
    assign w_adv    = i_pwr_done || w_expire;
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wd          <= '0;
            o_pwr_timeout <= 1'b0;
        end else begin
            r_wd          <= r_state == P_WAIT ? r_wd + 1'b1 : '0;
            o_pwr_timeout <= o_pwr_timeout | w_expire;
        end
    end
`else
    assign w_adv = i_pwr_done;
`endif
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= P_IDLE;
            o_pwr_start  <= 1'b0;
            o_pwr_bin    <= '0;
            o_frame_done <= 1'b0;
        end else begin
            case (r_state)
                P_IDLE: if (i_snap) begin
                    r_state     <= P_ISSUE;
                    o_pwr_start <= 1'b1;
                    o_pwr_bin   <= '0;
                end
                P_ISSUE: begin
                    r_state     <= P_WAIT;
                    o_pwr_start <= 1'b0;
                end
                P_WAIT: if (w_adv) begin
                    if (o_pwr_bin == LAST_BIN) begin
                        r_state      <= P_FIN;
                        o_frame_done <= 1'b1;
                    end else begin
                        r_state     <= P_ISSUE;
                        o_pwr_start <= 1'b1;
                        o_pwr_bin   <= o_pwr_bin + 1'b1;
                    end
                end
                default: begin
                    r_state      <= P_IDLE;
                    o_frame_done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/goertzel_sched.sv
// goertzel_sched: shares one recurrence unit across bins and hands blocks to the power walker; pwr_timeout with GOERTZEL_SCHED_TIMEOUT_EN
module goertzel_sched
    import goertzel_pkg::*;
#(
    parameter int NUM_BINS  = DEF_NUM_BINS,
    parameter int BLOCK_LEN = DEF_BLOCK_LEN,
`ifdef GOERTZEL_SCHED_TIMEOUT_EN
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
`endif
    localparam int BIN_W = NUM_BINS > 1 ? $clog2(NUM_BINS) : 1,
    localparam int CNT_W = $clog2(BLOCK_LEN)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_sample_valid,
    output logic             o_rec_start,
    output logic [BIN_W-1:0] o_rec_bin,
    input  logic             i_rec_done,
    output logic             o_blk_clear,
    output logic             o_blk_snap,
    output logic             o_pwr_start,
    output logic [BIN_W-1:0] o_pwr_bin,
    input  logic             i_pwr_done,
    output logic             o_frame_done,
    output logic [CNT_W-1:0] o_sample_cnt,
    output logic             o_busy,
    output logic             o_overrun,
    output logic             o_pwr_miss,
`ifdef GOERTZEL_SCHED_TIMEOUT_EN
    output logic             o_pwr_timeout,
`endif
    output logic             o_proto_err
);
    localparam int OUT_W = BIN_W + 1;
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);
    rec_state_t       r_state;
    logic [OUT_W-1:0] r_out;
    logic             w_rec_err;
    logic             w_pwr_busy;
    logic             w_pwr_err;
    assign w_rec_err = i_rec_done && r_out == '0;
    assign o_busy    = r_state != S_IDLE || w_pwr_busy;
    goertzel_pwr_seq #(
        .NUM_BINS(NUM_BINS),
`ifdef GOERTZEL_SCHED_TIMEOUT_EN
        .TIMEOUT_CYC(TIMEOUT_CYC),
`endif
        .BIN_W(BIN_W)
    ) u_pwr (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .i_snap(o_blk_snap),
        .i_pwr_done(i_pwr_done),
        .o_pwr_start(o_pwr_start),
        .o_pwr_bin(o_pwr_bin),
        .o_frame_done(o_frame_done),
        .o_busy(w_pwr_busy),
`ifdef GOERTZEL_SCHED_TIMEOUT_EN
        .o_pwr_timeout(o_pwr_timeout),
`endif
        .o_proto_err(w_pwr_err)
    );
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_out        <= '0;
            o_rec_start  <= 1'b0;
            o_rec_bin    <= '0;
            o_blk_clear  <= 1'b0;
            o_blk_snap   <= 1'b0;
            o_sample_cnt <= '0;
            o_overrun    <= 1'b0;
            o_pwr_miss   <= 1'b0;
            o_proto_err  <= 1'b0;
        end else begin
            // a stray rec_done is flagged and must not underflow the count
            r_out       <= r_out + OUT_W'(o_rec_start) - OUT_W'(i_rec_done && !w_rec_err);
            o_proto_err <= o_proto_err | w_rec_err | w_pwr_err;
            o_overrun   <= o_overrun | (i_sample_valid && r_state != S_IDLE);
            case (r_state)
                S_IDLE: if (i_enable && i_sample_valid) begin
                    r_state     <= S_ISSUE;
                    o_rec_start <= 1'b1;
                    o_rec_bin   <= '0;
                end
                S_ISSUE: if (o_rec_bin == LAST_BIN) begin
                    r_state     <= S_DRAIN;
                    o_rec_start <= 1'b0;
                end else begin
                    o_rec_bin <= o_rec_bin + 1'b1;
                end
                S_DRAIN: if (r_out == '0) begin
                    if (o_sample_cnt == LAST_CNT) begin
                        r_state     <= S_BOUND;
                        o_blk_clear <= 1'b1;
                        o_blk_snap  <= !w_pwr_busy;
                        o_pwr_miss  <= o_pwr_miss | w_pwr_busy;
                    end else begin
                        r_state      <= S_IDLE;
                        o_sample_cnt <= o_sample_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    o_blk_clear  <= 1'b0;
                    o_blk_snap   <= 1'b0;
                    o_sample_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_goertzel_sched.sv
// tb_goertzel_sched: scoreboard bench with latency models of the recurrence and power units
module tb_goertzel_sched;
    typedef struct {
        int bin;
        int cyc;
    } rev_t;
    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_enable = 1'b1;
    logic       i_sample_valid = 1'b0;
    logic       o_rec_start;
    logic [1:0] o_rec_bin;
    logic       i_rec_done;
    logic       o_blk_clear;
    logic       o_blk_snap;
    logic       o_pwr_start;
    logic [1:0] o_pwr_bin;
    logic       i_pwr_done;
    logic       o_frame_done;
    logic [2:0] o_sample_cnt;
    logic       o_busy;
    logic       o_overrun;
    logic       o_pwr_miss;
    logic       o_proto_err;
`ifdef GOERTZEL_SCHED_TIMEOUT_EN
    logic       o_pwr_timeout;
`endif
    logic       rec_mdl = 1'b0;
    logic       pwr_mdl = 1'b0;
    logic       inj_rec = 1'b0;
    logic       inj_pwr = 1'b0;
    logic       stall = 1'b0;
    logic [6:0] rpipe = '0;
    int         pcnt = 0;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         clr_n = 0;
    int         snap_n = 0;
    int         frame_n = 0;
    rev_t       rq[$];
    int         pq[$];

    assign i_rec_done = rec_mdl | inj_rec;
    assign i_pwr_done = pwr_mdl | inj_pwr;

    goertzel_sched #(.NUM_BINS(4), .BLOCK_LEN(8)) dut (
        .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable), .i_sample_valid(i_sample_valid),
        .o_rec_start(o_rec_start), .o_rec_bin(o_rec_bin), .i_rec_done(i_rec_done),
        .o_blk_clear(o_blk_clear), .o_blk_snap(o_blk_snap), .o_pwr_start(o_pwr_start),
        .o_pwr_bin(o_pwr_bin), .i_pwr_done(i_pwr_done), .o_frame_done(o_frame_done),
        .o_sample_cnt(o_sample_cnt), .o_busy(o_busy), .o_overrun(o_overrun),
        .o_pwr_miss(o_pwr_miss),
`ifdef GOERTZEL_SCHED_TIMEOUT_EN
        .o_pwr_timeout(o_pwr_timeout),
`endif
        .o_proto_err(o_proto_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // recurrence unit: result six cycles after issue
    always @(negedge clk) begin
        rpipe   = i_reset ? 7'd0 : {rpipe[5:0], o_rec_start};
        rec_mdl = rpipe[6];
    end

    // power unit: result ten cycles after start, never while stalled
    always @(negedge clk) begin
        pwr_mdl = 1'b0;
        if (i_reset || stall) pcnt = 0;
        else if (o_pwr_start) pcnt = 10;
        else if (pcnt > 0) begin
            pcnt--;
            pwr_mdl = pcnt == 0;
        end
    end

    always @(negedge clk) begin : mon
        rev_t e;
        int   b;
        if (o_rec_start) begin
            if (rq.size() == 0) check("rec_extra", 1, 0);
            else begin
                e = rq.pop_front();
                check("rec_bin", o_rec_bin, e.bin);
                check("rec_cyc", cyc, e.cyc);
            end
        end
        if (o_pwr_start) begin
            if (pq.size() == 0) check("pwr_extra", 1, 0);
            else begin
                b = pq.pop_front();
                check("pwr_bin", o_pwr_bin, b);
            end
        end
        if (o_blk_clear) clr_n++;
        if (o_blk_clear && o_blk_snap) snap_n++;
        if (o_frame_done) frame_n++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input bit accept);
        i_sample_valid = 1'b1;
        if (accept) for (int b = 0; b < 4; b++) rq.push_back('{b, cyc + 1 + b});
        tick(1);
        i_sample_valid = 1'b0;
    endtask

    task automatic spaced(input int n);
        for (int i = 0; i < n; i++) begin
            send(1);
            tick(19);
        end
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        tick(2);
        rq.delete();
        pq.delete();
        clr_n = 0;
        snap_n = 0;
        frame_n = 0;
        i_reset = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (o_busy && n < limit) begin
            tick(1);
            n++;
        end
        if (o_busy) check(tag, 1, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {o_rec_start, o_rec_bin, o_blk_clear, o_blk_snap, o_pwr_start, o_pwr_bin,
                    o_frame_done, o_sample_cnt, o_busy, o_overrun, o_pwr_miss, o_proto_err}, 0);
    endtask

    initial begin
        tick(3);
        check_all_zero("reset_outs");
        i_reset = 1'b0;
        while (cyc < 10) tick(1);
        send(1);
        tick(19);
        check("t1_cnt", o_sample_cnt, 1);
        check("t1_busy", o_busy, 0);
        check("t1_rq", rq.size(), 0);
        i_enable = 1'b0;
        send(0);
        i_enable = 1'b1;
        tick(19);
        check("en_cnt", o_sample_cnt, 1);
        check("en_ovr", o_overrun, 0);
        send(1);
        tick(2);
        send(0);
        tick(19);
        check("t3_ovr", o_overrun, 1);
        check("t3_cnt", o_sample_cnt, 2);
        check("t3_proto", o_proto_err, 0);
        spaced(5);
        check("t2_cnt7", o_sample_cnt, 7);
        check("t2_clr0", clr_n, 0);
        for (int b = 0; b < 4; b++) pq.push_back(b);
        spaced(1);
        check("t2_clr", clr_n, 1);
        check("t2_snap", snap_n, 1);
        check("t2_cnt0", o_sample_cnt, 0);
        wait_idle("t2_idle", 300);
        check("t2_frame", frame_n, 1);
        check("t2_pq", pq.size(), 0);
        check("t2_miss", o_pwr_miss, 0);

        do_reset();
        check("t5_proto0", o_proto_err, 0);
        inj_rec = 1'b1;
        tick(1);
        inj_rec = 1'b0;
        tick(1);
        check("t5_proto_rec", o_proto_err, 1);
        spaced(1);
        check("t5_cnt", o_sample_cnt, 1);
        check("t5_busy", o_busy, 0);
        do_reset();
        inj_pwr = 1'b1;
        tick(1);
        inj_pwr = 1'b0;
        tick(1);
        check("t5_proto_pwr", o_proto_err, 1);

        do_reset();
        stall = 1'b1;
        pq.push_back(0);
`ifdef GOERTZEL_SCHED_TIMEOUT_EN
        for (int b = 1; b < 4; b++) pq.push_back(b);
`endif
        spaced(8);
        check("t4_snap1", snap_n, 1);
        check("t4_miss0", o_pwr_miss, 0);
        spaced(8);
        check("t4_clr", clr_n, 2);
        check("t4_snap", snap_n, 1);
        check("t4_miss", o_pwr_miss, 1);
        check("t4_cnt", o_sample_cnt, 0);
`ifdef GOERTZEL_SCHED_TIMEOUT_EN
        wait_idle("t6_wd_idle", 400);
        check("t6_timeout", o_pwr_timeout, 1);
        check("t6_pq", pq.size(), 0);
`else
        check("t4_stuck", o_busy, 1);
`endif
        stall = 1'b0;

        do_reset();
        send(1);
        tick(2);
        check("t6_bin2", o_rec_bin, 2);
        i_reset = 1'b1;
        tick(1);
        rq.delete();
        check_all_zero("t6_reset");
        i_reset = 1'b0;
        tick(20);
        check("t6_proto", o_proto_err, 0);
        check("t6_cnt", o_sample_cnt, 0);
        check("end_rq", rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule
